scale_clip_pipe: RTL and testbench

//  Pipelined, parametrised block-floating-point scale/clip stage after the FFT core. Applies a per-symbol

---
 rtl/scale_clip_pipe_if.sv | 42 ++++
 rtl/scale_clip_pipe.sv | 185 ++++++++++++++++++
 tb/tb_scale_clip_pipe.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scale_clip_pipe_if.sv
// Handshake/data bundle for scale_clip_pipe.
//   slave  : the scaling block (consumes din_*, produces dout_*)
//   master : the environment (produces din_*, consumes dout_*)
// Signals:
//   din_valid/din_ready/din_sop, sc_real_din/sc_imag_din, exp  - input sample stream
//   dout_valid/dout_ready/dout_sop/dout_eop                      - output sample stream
//   sc_real_dout/sc_imag_dout, dout_clip, clip_cnt, sync_err     - output data and status
interface scale_clip_pipe_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 18,
    parameter int unsigned EXP_W = 6,
    parameter int unsigned CNT_W = 7
);
    logic                    din_valid;
    logic                    din_ready;
    logic                    din_sop;
    logic signed [IN_W-1:0]  sc_real_din;
    logic signed [IN_W-1:0]  sc_imag_din;
    logic signed [EXP_W-1:0] exp;

    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_sop;
    logic                    dout_eop;
    logic signed [OUT_W-1:0] sc_real_dout;
    logic signed [OUT_W-1:0] sc_imag_dout;
    logic                    dout_clip;
    logic [CNT_W-1:0]        clip_cnt;
    logic                    sync_err;

    modport slave (
        input  din_valid, din_sop, sc_real_din, sc_imag_din, exp, dout_ready,
        output din_ready, dout_valid, dout_sop, dout_eop, sc_real_dout, sc_imag_dout,
               dout_clip, clip_cnt, sync_err
    );

    modport master (
        output din_valid, din_sop, sc_real_din, sc_imag_din, exp, dout_ready,
        input  din_ready, dout_valid, dout_sop, dout_eop, sc_real_dout, sc_imag_dout,
               dout_clip, clip_cnt, sync_err
    );
endinterface

// File: rtl/scale_clip_pipe.sv
// Block-floating-point scale/clip stage placed after the FFT core.
// Each complex sample is shifted by the exponent latched on the symbol's sop (left shift for
// positive, round-half-up arithmetic right shift for negative), then symmetrically saturated
// to OUT_W bits. Two-stage pipeline (S1 shift/round, S2 saturate) advancing on
// en = !dout_valid | dout_ready, giving one sample per clock when downstream is ready.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous reset, active low
//   bus   - scale_clip_pipe_if.slave: valid/ready input stream with sop and exponent,
//           valid/ready output stream with sop/eop, clip flag, per-symbol clip count and
//           sync_err pulse
module scale_clip_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 18,
    parameter int unsigned EXP_W = 6,
    parameter int unsigned NFFT  = 64,
    parameter int unsigned CNT_W = 7
) (
    input logic              clk,
    input logic              rst_n,
    scale_clip_pipe_if.slave bus
);
    // Wide enough that the largest left shift cannot overflow.
    localparam int unsigned WideW = IN_W + (1 << (EXP_W - 1));
    localparam int unsigned IdxW  = $clog2(NFFT);

    localparam logic signed [WideW-1:0] SatMax = {{(WideW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WideW-1:0] SatMin = -SatMax;

    // Shift by signed exponent s: s >= 0 -> x << s, s < 0 -> (x + 2^(k-1)) >>> k with k = -s.
    function automatic logic signed [WideW-1:0] scale_one(
        input logic signed [IN_W-1:0]  x,
        input logic signed [EXP_W-1:0] s
    );
        logic signed [WideW-1:0] xe;
        logic signed [WideW-1:0] bias;
        logic [EXP_W-1:0]        k;
        xe = {{(WideW-IN_W){x[IN_W-1]}}, x};
        if (!s[EXP_W-1]) begin
            return xe <<< s;
        end
        k    = -s;
        bias = {{(WideW-1){1'b0}}, 1'b1} << (k - 1'b1);
        return (xe + bias) >>> k;
    endfunction

    // Returns {clipped, value}; -2^(OUT_W-1) is never produced.
    function automatic logic [OUT_W:0] sat_one(input logic signed [WideW-1:0] v);
        if (v > SatMax) begin
            return {1'b1, SatMax[OUT_W-1:0]};
        end
        if (v < SatMin) begin
            return {1'b1, SatMin[OUT_W-1:0]};
        end
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic en;
    logic accept;

    // Front end state
    logic [IdxW-1:0]         idx_q;
    logic signed [EXP_W-1:0] exp_q;

    // S1 registers
    logic                    s1_valid_q;
    logic                    s1_sop_q;
    logic                    s1_eop_q;
    logic                    s1_err_q;
    logic signed [WideW-1:0] s1_real_q;
    logic signed [WideW-1:0] s1_imag_q;

    // S2 (output) registers
    logic                    dout_valid_q;
    logic                    dout_sop_q;
    logic                    dout_eop_q;
    logic [OUT_W-1:0]        real_q;
    logic [OUT_W-1:0]        imag_q;
    logic                    clip_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    err_q;
    logic [CNT_W-1:0]        clip_acc_q;

    // Combinational next-state
    logic signed [EXP_W-1:0] exp_cur;
    logic [IdxW-1:0]         samp_idx;
    logic                    sync_err_in;
    logic signed [WideW-1:0] s1_real_d;
    logic signed [WideW-1:0] s1_imag_d;
    logic                    real_clip;
    logic                    imag_clip;
    logic [OUT_W-1:0]        real_sat;
    logic [OUT_W-1:0]        imag_sat;
    logic                    s2_clip;
    logic [CNT_W-1:0]        cnt_base;
    logic [CNT_W-1:0]        cnt_new;

    assign en            = !dout_valid_q || bus.dout_ready;
    assign accept        = bus.din_valid && en;
    assign bus.din_ready = en;

    always_comb begin
        // A sop sample uses its own exponent and is always index 0.
        exp_cur     = bus.din_sop ? bus.exp : exp_q;
        samp_idx    = bus.din_sop ? '0 : idx_q;
        sync_err_in = bus.din_sop ? (idx_q != '0) : (idx_q == '0);
        s1_real_d   = scale_one(bus.sc_real_din, exp_cur);
        s1_imag_d   = scale_one(bus.sc_imag_din, exp_cur);
    end

    always_comb begin
        {real_clip, real_sat} = sat_one(s1_real_q);
        {imag_clip, imag_sat} = sat_one(s1_imag_q);
        s2_clip  = real_clip || imag_clip;
        // Index 0 restarts the count, so a mid-symbol resync drops the partial tally.
        cnt_base = s1_sop_q ? '0 : clip_acc_q;
        cnt_new  = cnt_base + {{(CNT_W-1){1'b0}}, s2_clip};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= '0;
            exp_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_sop_q     <= 1'b0;
            s1_eop_q     <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_real_q    <= '0;
            s1_imag_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            real_q       <= '0;
            imag_q       <= '0;
            clip_q       <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            clip_acc_q   <= '0;
        end else begin
            if (accept) begin
                idx_q <= samp_idx + 1'b1;
                if (bus.din_sop) begin
                    exp_q <= bus.exp;
                end
            end
            if (en) begin
                s1_valid_q   <= bus.din_valid;
                s1_sop_q     <= accept && (samp_idx == '0);
                s1_eop_q     <= accept && (samp_idx == IdxW'(NFFT - 1));
                s1_err_q     <= accept && sync_err_in;
                s1_real_q    <= s1_real_d;
                s1_imag_q    <= s1_imag_d;
                dout_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    dout_sop_q <= s1_sop_q;
                    dout_eop_q <= s1_eop_q;
                    real_q     <= real_sat;
                    imag_q     <= imag_sat;
                    clip_q     <= s2_clip;
                    err_q      <= s1_err_q;
                    cnt_q      <= s1_eop_q ? cnt_new : '0;
                    clip_acc_q <= s1_eop_q ? '0 : cnt_new;
                end else begin
                    // Bubble: clear flags so sync_err/eop stay single-sample pulses.
                    dout_sop_q <= 1'b0;
                    dout_eop_q <= 1'b0;
                    real_q     <= '0;
                    imag_q     <= '0;
                    clip_q     <= 1'b0;
                    err_q      <= 1'b0;
                    cnt_q      <= '0;
                end
            end
        end
    end

    assign bus.dout_valid   = dout_valid_q;
    assign bus.dout_sop     = dout_sop_q;
    assign bus.dout_eop     = dout_eop_q;
    assign bus.sc_real_dout = real_q;
    assign bus.sc_imag_dout = imag_q;
    assign bus.dout_clip    = clip_q;
    assign bus.clip_cnt     = cnt_q;
    assign bus.sync_err     = err_q;
endmodule

// File: tb/tb_scale_clip_pipe.sv
// Self-checking bench for scale_clip_pipe: directed steps plus randomized streams scored
// against an arithmetic reference model of scaling, saturation, framing and clip counting.
module tb_scale_clip_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 18;
    localparam int EXP_W = 6;
    localparam int NFFT  = 64;
    localparam int CNT_W = 7;
    localparam longint SAT = (longint'(1) <<< (OUT_W - 1)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scale_clip_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W), .CNT_W(CNT_W)) bus ();

    scale_clip_pipe #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .EXP_W(EXP_W),
        .NFFT (NFFT),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        longint re;
        longint im;
        bit     clip;
        bit     sop;
        bit     eop;
        int     cnt;
        bit     serr;
    } exp_t;

    exp_t   q[$];
    int     errors = 0;
    int     checks = 0;
    int     m_idx, m_exp, m_clip;
    int     eop_cnts[$];
    int     serr_seen = 0;
    int     stall_hits = 0;
    int     stall_left = 0;
    bit     rand_rdy = 1'b0;
    longint last_re, last_im;
    bit     last_clip;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint ref_scale(input longint x, input int e);
        longint v;
        if (e >= 0) return x * (longint'(1) <<< e);
        v = x + (longint'(1) <<< (-e - 1));
        return v >>> (-e);
    endfunction

    function automatic longint ref_sat(input longint v);
        if (v > SAT) return SAT;
        if (v < -SAT) return -SAT;
        return v;
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    task automatic model_in();
        exp_t   t;
        int     e, sidx;
        longint r, i;
        e = bus.din_sop ? int'(bus.exp) : m_exp;
        if (bus.din_sop) m_exp = e;
        sidx   = bus.din_sop ? 0 : m_idx;
        t.serr = bus.din_sop ? (m_idx != 0) : (m_idx == 0);
        m_idx  = (sidx + 1) % NFFT;
        r      = ref_scale(longint'(bus.sc_real_din), e);
        i      = ref_scale(longint'(bus.sc_imag_din), e);
        t.re   = ref_sat(r);
        t.im   = ref_sat(i);
        t.clip = (r != t.re) || (i != t.im);
        t.sop  = (sidx == 0);
        t.eop  = (sidx == NFFT - 1);
        if (sidx == 0) m_clip = 0;
        m_clip += int'(t.clip);
        t.cnt  = t.eop ? m_clip : 0;
        if (t.eop) m_clip = 0;
        q.push_back(t);
    endtask

    task automatic check_out();
        exp_t t;
        if (q.size() == 0) begin
            chk("spurious dout_valid", bus.dout_valid, 0);
            return;
        end
        t = q.pop_front();
        chk("dout_re", $signed(bus.sc_real_dout), t.re);
        chk("dout_im", $signed(bus.sc_imag_dout), t.im);
        chk("dout_clip", bus.dout_clip, t.clip);
        chk("dout_sop", bus.dout_sop, t.sop);
        chk("dout_eop", bus.dout_eop, t.eop);
        chk("clip_cnt", bus.clip_cnt, t.cnt);
        chk("sync_err", bus.sync_err, t.serr);
        last_re   = $signed(bus.sc_real_dout);
        last_im   = $signed(bus.sc_imag_dout);
        last_clip = bus.dout_clip;
        if (bus.dout_eop) eop_cnts.push_back(int'(bus.clip_cnt));
        if (bus.sync_err) serr_seen++;
    endtask

    // Called at a falling edge with inputs set; samples, scores, then advances one clock.
    task automatic tick(output bit acc);
        if (stall_left > 0) begin
            bus.dout_ready = 1'b0;
            stall_left--;
        end else begin
            bus.dout_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
        end
        #1;
        acc = bus.din_valid && bus.din_ready;
        if (bus.dout_valid && !bus.dout_ready) begin
            stall_hits++;
            chk("stall din_ready", bus.din_ready, 0);
            if (q.size() != 0) begin
                chk("stall hold re", $signed(bus.sc_real_dout), q[0].re);
                chk("stall hold im", $signed(bus.sc_imag_dout), q[0].im);
                chk("stall hold eop", bus.dout_eop, q[0].eop);
            end
        end
        if (bus.dout_valid && bus.dout_ready) check_out();
        if (acc) model_in();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input bit sop, input int e, input int re, input int im);
        bit acc;
        int n;
        bus.din_valid   = 1'b1;
        bus.din_sop     = sop;
        bus.exp         = e[EXP_W-1:0];
        bus.sc_real_din = re[IN_W-1:0];
        bus.sc_imag_din = im[IN_W-1:0];
        n = 0;
        do begin
            tick(acc);
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("din accept timeout", acc, 1);
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
        repeat (n) tick(acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
        while ((q.size() != 0 || bus.dout_valid) && n < 200) begin
            tick(acc);
            n++;
        end
        chk("drain leftover", q.size(), 0);
    endtask

    task automatic do_reset();
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst dout_valid", bus.dout_valid, 0);
        chk("rst dout_sop", bus.dout_sop, 0);
        chk("rst dout_eop", bus.dout_eop, 0);
        chk("rst re", bus.sc_real_dout, 0);
        chk("rst im", bus.sc_imag_dout, 0);
        chk("rst clip", bus.dout_clip, 0);
        chk("rst clip_cnt", bus.clip_cnt, 0);
        chk("rst sync_err", bus.sync_err, 0);
        q.delete();
        m_idx  = 0;
        m_exp  = 0;
        m_clip = 0;
        rst_n  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int e, re, n_eop, n_serr;
        bus.din_valid   = 1'b0;
        bus.din_sop     = 1'b0;
        bus.exp         = '0;
        bus.sc_real_din = '0;
        bus.sc_imag_din = '0;
        bus.dout_ready  = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // T1: exp=2 and two-cycle latency
        bus.din_valid   = 1'b1;
        bus.din_sop     = 1'b1;
        bus.exp         = 6'sd2;
        bus.sc_real_din = 16'sd4096;
        bus.sc_imag_din = -16'sd4096;
        tick(acc);
        chk("T1 accepted", acc, 1);
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
        chk("T1 not yet valid", bus.dout_valid, 0);
        tick(acc);
        chk("T1 valid after 2", bus.dout_valid, 1);
        chk("T1 re", $signed(bus.sc_real_dout), 16384);
        chk("T1 im", $signed(bus.sc_imag_dout), -16384);
        chk("T1 clip", bus.dout_clip, 0);
        drain();

        // T2: saturation, symmetric on the negative side
        send(1'b1, 3, 32767, -32768);
        drain();
        chk("T2 re", last_re, 131071);
        chk("T2 im", last_im, -131071);
        chk("T2 clip", last_clip, 1);

        // T3: rounded right shifts, including a shift past the input width
        send(1'b1, -2, 7, -7);
        drain();
        chk("T3 re", last_re, 2);
        chk("T3 im", last_im, -2);
        send(1'b1, -20, 32767, -32768);
        drain();
        chk("T3 big shift re", last_re, 0);
        chk("T3 big shift im", last_im, 0);

        // T5: five clips incl. the eop sample, then sop+clip on the next symbol
        do_reset();
        n_eop = eop_cnts.size();
        for (int i = 0; i < NFFT; i++) begin
            re = (i == 3 || i == 17 || i == 31 || i == 50 || i == 63) ? 20000 : rnd(-16383, 16383);
            send(i == 0, 3, re, rnd(-16383, 16383));
        end
        for (int i = 0; i < NFFT; i++) begin
            re = (i == 0) ? -20000 : rnd(-16383, 16383);
            send(i == 0, 3, re, rnd(-16383, 16383));
        end
        drain();
        chk("T5 eop count", eop_cnts.size() - n_eop, 2);
        if (eop_cnts.size() >= n_eop + 2) begin
            chk("T5 clip_cnt sym0", eop_cnts[n_eop], 5);
            chk("T5 clip_cnt sym1", eop_cnts[n_eop + 1], 1);
        end

        // T4: random stream with random backpressure and a forced 3-cycle stall
        rand_rdy   = 1'b1;
        stall_hits = 0;
        for (int s = 0; s < 3; s++) begin
            e = (s == 0) ? rnd(-4, 4) : rnd(-32, 31);
            for (int i = 0; i < NFFT; i++) begin
                if (s == 0 && i == 20) stall_left = 3;
                if ($urandom_range(7) == 0) idle(1);
                send(i == 0, e, rnd(-32768, 32767), rnd(-32768, 32767));
            end
        end
        drain();
        rand_rdy = 1'b0;
        chk("T4 stall observed", stall_hits > 0, 1);

        // T6: sop on sample 30, then reset mid-symbol
        do_reset();
        n_serr = serr_seen;
        for (int i = 0; i < 30; i++) send(i == 0, 0, rnd(-32768, 32767), rnd(-32768, 32767));
        send(1'b1, 1, rnd(-32768, 32767), rnd(-32768, 32767));
        for (int i = 0; i < 10; i++) send(1'b0, 0, rnd(-32768, 32767), rnd(-32768, 32767));
        chk("T6 sync_err pulses", serr_seen - n_serr, 1);
        n_eop = eop_cnts.size();
        do_reset();
        idle(5);
        chk("T6 no eop after reset", eop_cnts.size() - n_eop, 0);
        chk("T6 idle valid", bus.dout_valid, 0);
        for (int i = 0; i < NFFT; i++) send(i == 0, -1, rnd(-32768, 32767), rnd(-32768, 32767));
        drain();
        chk("T6 clean symbol eop", eop_cnts.size() - n_eop, 1);
        chk("T6 clean symbol sync", serr_seen - n_serr, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
